// File: rtl/orb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : orb_pkg
// Description : Shared types and helpers for the orbit frame writer.
// Revision    : 1.0 - initial release
// ============================================================================
package orb_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    MARK_WORD  = 3'd2,
    DATA_CHECK = 3'd3,
    COLLECT    = 3'd4,
    WRITE      = 3'd5,
    ADVANCE    = 3'd6
  } orb_state_e;

  // A zero period disables reserved slots entirely.
  function automatic logic is_reserved(input logic [31:0] addr, input int period, input int phase);
    logic res;
    if (period == 0) res = 1'b0;
    else             res = ((addr & 32'(period - 1)) == 32'(phase));
    return res;
  endfunction

  // With period >= 2 two reserved slots are never adjacent, so one hop suffices.
  function automatic logic [31:0] next_writable(input logic [31:0] addr, input int period, input int phase);
    logic [31:0] n;
    n = addr + 32'd1;
    if (is_reserved(n, period, phase)) n = n + 32'd1;
    return n;
  endfunction

  function automatic logic odd_parity(input logic [63:0] v);
    return ~^v;
  endfunction

  // Builds {M', B'}: M inverted by v[0], B inverted by v[1].
  function automatic logic [127:0] marker_variant(input logic [1:0] v, input logic [127:0] m,
                                                  input logic [127:0] b, input int hiW, input int loW);
    logic [127:0] mm;
    logic [127:0] bb;
    for (int i = 0; i < 128; i++) begin
      mm[i] = (i < hiW) ? (m[i] ^ v[0]) : 1'b0;
      bb[i] = (i < loW) ? (b[i] ^ v[1]) : 1'b0;
    end
    return (mm << loW) | bb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/orb_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : orb_bit_packer
// Description : Serial-to-parallel valid/ready shifter, MSB first, with word-done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module orb_bit_packer #(
  parameter int WORD_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              bitData,
  input  logic              bitValid,
  output logic              bitReady,
  output logic [WORD_W-1:0] word,
  output logic              done
);

  localparam int c_cntW = $clog2(WORD_W);

  logic [c_cntW-1:0] r_cnt;
  logic [WORD_W-2:0] r_shift;
  logic              w_hs;

  assign w_hs     = en & bitValid;
  assign bitReady = en;
  // The completed word includes the bit being accepted this cycle.
  assign word     = {r_shift, bitData};
  assign done     = w_hs && (r_cnt == c_cntW'(WORD_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_hs) begin
      r_shift <= word[WORD_W-2:0];
      r_cnt   <= done ? '0 : r_cnt + c_cntW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/orb_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : orb_frame_writer
// Description : Fills one ping-pong orbit RAM half per buffer switch with marker/data frames.
// Revision    : 1.0 - initial release
// ============================================================================
module orb_frame_writer #(
  parameter int WORD_W      = 11,
  parameter int RAM_AW      = 10,
  parameter int MARK_WORDS  = 4,
  parameter int MARK_HI_W   = 31,
  parameter int MARK_LO_W   = 13,
  parameter int DATA_WORDS  = 256,
  parameter int LVL_W       = 15,
  parameter int START_LEVEL = 10240,
  parameter int SKIP_PERIOD = 4,
  parameter int SKIP_PHASE  = 0,
  parameter int PARITY_EN   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 buf_switch,
  input  logic [MARK_HI_W-1:0] mark_m,
  input  logic [MARK_LO_W-1:0] mark_b,
  input  logic                 bit_data,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  input  logic [LVL_W-1:0]     bit_level,
  output logic [WORD_W:0]      orb_word,
  output logic [RAM_AW-1:0]    orb_addr,
  output logic                 orb_wren,
  output logic                 busy,
  output logic                 underflow,
  output logic                 switch_err,
  output logic [1:0]           frame_cnt
);
  import orb_pkg::*;

  localparam int c_markBits = MARK_WORDS * WORD_W;
  localparam int c_frameLen = MARK_WORDS + DATA_WORDS;
  localparam int c_idxW     = $clog2(c_frameLen);
  localparam logic [RAM_AW-1:0] c_firstAddr =
    is_reserved(32'd0, SKIP_PERIOD, SKIP_PHASE) ? RAM_AW'(1) : RAM_AW'(0);
  localparam logic [RAM_AW-1:0] c_lastAddr =
    is_reserved(32'((1 << RAM_AW) - 1), SKIP_PERIOD, SKIP_PHASE) ? RAM_AW'((1 << RAM_AW) - 2)
                                                                 : RAM_AW'((1 << RAM_AW) - 1);

  function automatic logic payload_parity(input logic [WORD_W-1:0] p);
    return (PARITY_EN != 0) && odd_parity(64'(p));
  endfunction

  orb_state_e          r_state, w_nextState;
  logic                r_bufSwitch, r_armed, r_underflow, r_switchErr;
  logic [WORD_W:0]     r_orbWord;
  logic [RAM_AW-1:0]   r_orbAddr;
  logic [c_idxW-1:0]   r_wordIdx, w_nextIdx;
  logic [1:0]          r_frameCnt;
  logic [c_markBits-1:0] w_marker;
  logic [WORD_W-1:0]   w_markWord, w_packWord;
  logic                w_toggle, w_short, w_atLast, w_isMark, w_nextIsMark, w_collect, w_wordDone;

  assign w_toggle     = r_bufSwitch ^ buf_switch;
  assign w_short      = bit_level < LVL_W'(WORD_W);
  assign w_atLast     = r_orbAddr == c_lastAddr;
  assign w_nextIdx    = (r_wordIdx == c_idxW'(c_frameLen - 1)) ? '0 : r_wordIdx + c_idxW'(1);
  assign w_isMark     = r_wordIdx < c_idxW'(MARK_WORDS);
  assign w_nextIsMark = w_nextIdx < c_idxW'(MARK_WORDS);
  assign w_marker     = c_markBits'(marker_variant(r_frameCnt, 128'(mark_m), 128'(mark_b),
                                                   MARK_HI_W, MARK_LO_W));

  always_comb begin
    w_markWord = '0;
    for (int k = 0; k < MARK_WORDS; k++)
      if (r_wordIdx == c_idxW'(k)) w_markWord = w_marker[c_markBits-1-k*WORD_W -: WORD_W];
  end

  orb_bit_packer #(.WORD_W(WORD_W)) u_packer (
    .clk      (clk),
    .reset    (reset),
    .en       (w_collect),
    .bitData  (bit_data),
    .bitValid (bit_valid),
    .bitReady (bit_ready),
    .word     (w_packWord),
    .done     (w_wordDone)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:       if (w_toggle && r_armed) w_nextState = START;
      START:      w_nextState = w_isMark ? MARK_WORD : DATA_CHECK;
      MARK_WORD:  w_nextState = WRITE;
      DATA_CHECK: w_nextState = w_short ? WRITE : COLLECT;
      COLLECT:    if (w_wordDone) w_nextState = WRITE;
      WRITE:      w_nextState = ADVANCE;
      ADVANCE:    w_nextState = w_atLast ? IDLE : (w_nextIsMark ? MARK_WORD : DATA_CHECK);
      default:    w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    orb_wren  = (r_state == WRITE);
    w_collect = (r_state == COLLECT);
  end

  // Frame position and marker variant survive buffer ends; only the address restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bufSwitch <= 1'b0;
      r_armed     <= 1'b0;
      r_underflow <= 1'b0;
      r_switchErr <= 1'b0;
      r_orbWord   <= '0;
      r_orbAddr   <= '0;
      r_wordIdx   <= '0;
      r_frameCnt  <= '0;
    end else begin
      r_bufSwitch <= buf_switch;
      r_underflow <= 1'b0;
      r_switchErr <= w_toggle && busy;
      if (bit_level >= LVL_W'(START_LEVEL)) r_armed <= 1'b1;
      case (r_state)
        START:     r_orbAddr <= c_firstAddr;
        MARK_WORD: r_orbWord <= {payload_parity(w_markWord), w_markWord};
        DATA_CHECK:
          if (w_short) begin
            r_orbWord   <= {payload_parity({WORD_W{1'b0}}), {WORD_W{1'b0}}};
            r_underflow <= 1'b1;
          end
        COLLECT:   if (w_wordDone) r_orbWord <= {payload_parity(w_packWord), w_packWord};
        ADVANCE: begin
          r_orbAddr <= w_atLast ? '0
                                : RAM_AW'(next_writable(32'(r_orbAddr), SKIP_PERIOD, SKIP_PHASE));
          r_wordIdx <= w_nextIdx;
          if (r_wordIdx == c_idxW'(MARK_WORDS - 1)) r_frameCnt <= r_frameCnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign orb_word   = r_orbWord;
  assign orb_addr   = r_orbAddr;
  assign underflow  = r_underflow;
  assign switch_err = r_switchErr;
  assign frame_cnt  = r_frameCnt;

endmodule
`default_nettype wire
